// File: rtl/ifetch.sv
// Instruction fetch stage: holds the PC, fetches one word per cycle from
// instruction memory, and buffers fetch packets in a 2-entry FIFO towards
// decode. Misaligned or faulting fetches produce a single exception packet
// and park the stage in HALT_EXC until a redirect arrives.
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // Instruction memory side
    output logic [63:0] pc_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    // Redirect from execute / CSR
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    // Decode side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_exc_en,
    output logic [3:0]  out_exc_code,
    output logic [63:0] out_exc_val,
    output logic        fetch_stalled
);

    // Canonical NOP (addi x0, x0, 0) placed in exception packets
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [3:0]  EXC_MISALIGN  = 4'd0;

    typedef enum logic {
        ST_FETCH    = 1'b0,
        ST_HALT_EXC = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    // FIFO storage, one array per packet field
    logic [63:0] ent_pc_q       [2];
    logic [31:0] ent_instr_q    [2];
    logic        ent_exc_en_q   [2];
    logic [3:0]  ent_exc_code_q [2];
    logic [63:0] ent_exc_val_q  [2];

    // Packet built this cycle from the current PC and memory response
    logic [63:0] pkt_pc;
    logic [31:0] pkt_instr;
    logic        pkt_exc_en;
    logic [3:0]  pkt_exc_code;
    logic [63:0] pkt_exc_val;

    logic        misaligned;
    logic        deq;
    logic        enq;

    assign pc_addr       = pc_q;
    assign out_valid     = (count_q != 2'd0);
    assign fetch_stalled = (state_q == ST_HALT_EXC);

    assign out_pc        = ent_pc_q[rd_ptr_q];
    assign out_instr     = ent_instr_q[rd_ptr_q];
    assign out_exc_en    = ent_exc_en_q[rd_ptr_q];
    assign out_exc_code  = ent_exc_code_q[rd_ptr_q];
    assign out_exc_val   = ent_exc_val_q[rd_ptr_q];

    assign misaligned    = (pc_q[1:0] != 2'b00);
    assign deq           = out_valid && out_ready;

    // Assemble the packet; misalignment is detected locally and takes
    // priority over anything memory reports for the same address
    always_comb begin
        pkt_pc       = pc_q;
        pkt_instr    = imem_instr;
        pkt_exc_en   = 1'b0;
        pkt_exc_code = 4'd0;
        pkt_exc_val  = 64'd0;
        if (misaligned) begin
            pkt_instr    = NOP_INSTR;
            pkt_exc_en   = 1'b1;
            pkt_exc_code = EXC_MISALIGN;
            pkt_exc_val  = pc_q;
        end else if (imem_exc_en) begin
            pkt_instr    = NOP_INSTR;
            pkt_exc_en   = 1'b1;
            pkt_exc_code = imem_exc_code;
            pkt_exc_val  = imem_exc_val;
        end
    end

    // Next-state logic: FSM, PC, FIFO occupancy and pointers; a redirect
    // wins over every other effect in the same cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        enq      = 1'b0;

        if (redirect_en) begin
            state_d  = ST_FETCH;
            pc_d     = redirect_pc;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    // A full FIFO still accepts a packet when the head leaves
                    enq = (count_q != 2'd2) || deq;
                    if (enq) begin
                        if (pkt_exc_en) begin
                            state_d = ST_HALT_EXC;
                        end else begin
                            pc_d = pc_q + 64'd4;
                        end
                    end
                end
                ST_HALT_EXC: begin
                    enq = 1'b0;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase

            if (enq) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (enq && !deq) begin
                count_d = count_q + 2'd1;
            end else if (!enq && deq) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    // Control state register: FSM, PC, occupancy and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage write; cleared on reset so the head reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]       <= 64'd0;
                ent_instr_q[i]    <= 32'd0;
                ent_exc_en_q[i]   <= 1'b0;
                ent_exc_code_q[i] <= 4'd0;
                ent_exc_val_q[i]  <= 64'd0;
            end
        end else if (enq) begin
            ent_pc_q[wr_ptr_q]       <= pkt_pc;
            ent_instr_q[wr_ptr_q]    <= pkt_instr;
            ent_exc_en_q[wr_ptr_q]   <= pkt_exc_en;
            ent_exc_code_q[wr_ptr_q] <= pkt_exc_code;
            ent_exc_val_q[wr_ptr_q]  <= pkt_exc_val;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed testbench for ifetch: a linear sequence of steps, each output
// checked on the falling clock edge against hand-computed values.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;
    logic        fetch_stalled;

    // Memory model controls
    logic        pat_mode;
    logic        fault_arm;
    logic [63:0] fault_pc;

    int vectors;
    int miscompares;

    ifetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr       (pc_addr),
        .imem_instr    (imem_instr),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_exc_en    (out_exc_en),
        .out_exc_code  (out_exc_code),
        .out_exc_val   (out_exc_val),
        .fetch_stalled (fetch_stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: either always NOP, or an
    // address-dependent word; optional access fault at one address
    assign imem_instr    = pat_mode ? (pc_addr[31:0] ^ 32'h5A5A_0000) : 32'h0000_0013;
    assign imem_exc_en   = fault_arm && (pc_addr == fault_pc);
    assign imem_exc_code = 4'd1;
    assign imem_exc_val  = pc_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 64'd0;
        pat_mode    = 1'b0;
        fault_arm   = 1'b0;
        fault_pc    = 64'd0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_pc_addr", pc_addr, 64'h0000_0000_8000_0000);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_exc_en", {63'd0, out_exc_en}, 64'd0);
        check("rst_out_exc_code", {60'd0, out_exc_code}, 64'd0);
        check("rst_out_exc_val", out_exc_val, 64'd0);
        check("rst_stalled", {63'd0, fetch_stalled}, 64'd0);

        // Streaming with decode always ready
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        check("s_valid0", {63'd0, out_valid}, 64'd1);
        check("s_pc0", out_pc, 64'h8000_0000);
        check("s_instr0", {32'd0, out_instr}, 64'h13);
        @(negedge clk);
        check("s_pc1", out_pc, 64'h8000_0004);
        check("s_valid1", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("s_pc2", out_pc, 64'h8000_0008);

        // Backpressure: FIFO fills to two, then drains in order
        out_ready = 1'b0;
        pat_mode  = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_pc_mid", out_pc, 64'h8000_0000);
        check("bp_addr_mid", pc_addr, 64'h8000_0008);
        repeat (2) @(negedge clk);
        check("bp_pc_hold", out_pc, 64'h8000_0000);
        check("bp_instr_hold", {32'd0, out_instr}, 64'hDA5A_0000);
        check("bp_addr_hold", pc_addr, 64'h8000_0008);
        check("bp_valid_hold", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pc_d1", out_pc, 64'h8000_0004);
        check("bp_instr_d1", {32'd0, out_instr}, 64'hDA5A_0004);
        @(negedge clk);
        check("bp_pc_d2", out_pc, 64'h8000_0008);
        check("bp_instr_d2", {32'd0, out_instr}, 64'hDA5A_0008);
        @(negedge clk);
        check("bp_pc_d3", out_pc, 64'h8000_000C);

        // Memory access fault, halt, then redirect out of HALT_EXC
        pat_mode    = 1'b0;
        fault_pc    = 64'h4000_0000;
        fault_arm   = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h4000_0000;
        @(negedge clk);
        redirect_en = 1'b0;
        check("af_flush_valid", {63'd0, out_valid}, 64'd0);
        check("af_addr", pc_addr, 64'h4000_0000);
        @(negedge clk);
        check("af_valid", {63'd0, out_valid}, 64'd1);
        check("af_pc", out_pc, 64'h4000_0000);
        check("af_exc_en", {63'd0, out_exc_en}, 64'd1);
        check("af_exc_code", {60'd0, out_exc_code}, 64'd1);
        check("af_exc_val", out_exc_val, 64'h4000_0000);
        check("af_instr", {32'd0, out_instr}, 64'h13);
        check("af_stalled", {63'd0, fetch_stalled}, 64'd1);
        repeat (3) @(negedge clk);
        check("af_no_more", {63'd0, out_valid}, 64'd0);
        check("af_pc_held", pc_addr, 64'h4000_0000);
        check("af_still_stalled", {63'd0, fetch_stalled}, 64'd1);
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0100;
        @(negedge clk);
        redirect_en = 1'b0;
        check("af_exit_stalled", {63'd0, fetch_stalled}, 64'd0);
        check("af_exit_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("af_next_pc", out_pc, 64'h8000_0100);
        check("af_next_exc", {63'd0, out_exc_en}, 64'd0);

        // Misaligned redirect target; misalignment outranks a memory fault
        fault_pc    = 64'h8000_0002;
        pat_mode    = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0002;
        @(negedge clk);
        redirect_en = 1'b0;
        @(negedge clk);
        check("ma_exc_en", {63'd0, out_exc_en}, 64'd1);
        check("ma_exc_code", {60'd0, out_exc_code}, 64'd0);
        check("ma_exc_val", out_exc_val, 64'h8000_0002);
        check("ma_instr", {32'd0, out_instr}, 64'h13);
        check("ma_stalled", {63'd0, fetch_stalled}, 64'd1);

        // PC wraps from the top of the address space to zero
        fault_arm   = 1'b0;
        pat_mode    = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_en = 1'b0;
        @(negedge clk);
        check("wr_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_exc", {63'd0, out_exc_en}, 64'd0);
        check("wr_addr", pc_addr, 64'd0);

        // Redirect while full with decode ready: flush wins
        out_ready   = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0200;
        @(negedge clk);
        redirect_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rf_full_pc", out_pc, 64'h8000_0200);
        check("rf_full_addr", pc_addr, 64'h8000_0208);
        out_ready   = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0300;
        @(negedge clk);
        redirect_en = 1'b0;
        check("rf_valid", {63'd0, out_valid}, 64'd0);
        check("rf_addr", pc_addr, 64'h8000_0300);
        @(negedge clk);
        check("rf_next_valid", {63'd0, out_valid}, 64'd1);
        check("rf_next_pc", out_pc, 64'h8000_0300);

        // Asynchronous reset while halted with a packet still buffered
        out_ready   = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h8000_0006;
        @(negedge clk);
        redirect_en = 1'b0;
        @(negedge clk);
        check("ar_pre_stalled", {63'd0, fetch_stalled}, 64'd1);
        check("ar_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {63'd0, out_valid}, 64'd0);
        check("ar_stalled", {63'd0, fetch_stalled}, 64'd0);
        check("ar_addr", pc_addr, 64'h8000_0000);
        check("ar_exc_en", {63'd0, out_exc_en}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_first_valid", {63'd0, out_valid}, 64'd1);
        check("ar_first_pc", out_pc, 64'h8000_0000);
        check("ar_first_stalled", {63'd0, fetch_stalled}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 SHALL have ports clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have pc_addr  output  64  fetch address to instruction memory, driven directly from PC register.
REQ-005 SHALL have imem_instr  input  32  instruction returned combinationally for pc_addr.
REQ-006 SHALL have imem_exc_en  input  1, imem_exc_code  input  4, imem_exc_val  input  64  memory-side fetch fault (code 1 = access fault, val = bad PC).
REQ-007 SHALL have redirect_en  input  1, redirect_pc  input  64  branch/trap/mret target from execute/CSR.
REQ-008 SHALL have out_valid  output  1, out_ready  input  1  valid/ready handshake to decode.
REQ-009 SHALL have out_pc  output  64, out_instr  output  32, out_exc_en  output  1, out_exc_code  output  4, out_exc_val  output  64  head-of-buffer fetch packet.
REQ-010 SHALL have fetch_stalled  output  1  high while in HALT_EXC.

Function
REQ-011 SHALL buffer fetch packets {pc, instr, exc_en, exc_code, exc_val} in a 2-entry FIFO; out_* show head entry; out_valid = (count != 0).
REQ-012 SHALL dequeue head on rising edge when out_valid && out_ready.
REQ-013 SHALL enqueue in state FETCH when count < 2, or count == 2 with dequeue same cycle; enqueue and dequeue same edge leave count unchanged.
REQ-014 SHALL, on enqueue of a fault-free packet, advance PC by 4 (modulo 2^64, 0xFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-015 SHALL hold PC and enqueue nothing when FIFO full with no dequeue.
REQ-016 SHALL, when PC[1:0] != 0 in FETCH, enqueue packet with exc_en=1, exc_code=0 (misaligned), exc_val=PC, instr=32'h00000013, ignoring imem inputs, and enter HALT_EXC.
REQ-017 SHALL, when imem_exc_en=1 at an enqueue, enqueue packet with exc_en=1, code/val from imem, instr=32'h00000013, hold PC, and enter HALT_EXC.
REQ-018 SHALL have two states: FETCH (issue/enqueue) and HALT_EXC (no enqueue, PC held, fetch_stalled=1); HALT_EXC exits only on redirect_en.
REQ-019 SHALL, on redirect_en=1, on that edge: flush FIFO (count=0), load PC=redirect_pc, state=FETCH, no enqueue; redirect overrides enqueue, dequeue-side effects and fault capture that cycle.
REQ-020 SHALL give one-cycle latency: instruction at pc_addr in cycle N appears on out_* with out_valid=1 in cycle N+1 when enqueued into empty FIFO.
REQ-021 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL enqueue at most one packet per cycle; one faulting packet per HALT_EXC entry.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously set PC=RESET_PC, count=0, state=FETCH, out_valid=0, fetch_stalled=0, FIFO storage zeroed so out_pc/out_instr/out_exc_*=0.
REQ-024 SHALL discard all in-flight packets and any HALT_EXC state on reset mid-operation; first fetch after release is at RESET_PC.

Verification
REQ-025 Reset release, out_ready=1, imem returns 0x00000013 -> out_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, out_valid=1 from cycle 1.
REQ-026 out_ready=0 for 4 cycles after reset -> count saturates at 2, pc_addr holds 0x8000_0008, out_pc stays 0x8000_0000; out_ready=1 -> 0x8000_0000, 0x8000_0004, 0x8000_0008 in order, none lost or duplicated.
REQ-027 imem_exc_en=1, code 1, val 0x4000_0000 at pc 0x4000_0000 -> packet out_exc_en=1, code 1, val 0x4000_0000, instr 0x13; fetch_stalled=1; no further packets until redirect_en with 0x8000_0100 -> next out_pc 0x8000_0100.
REQ-028 redirect_en with redirect_pc 0x8000_0002 -> packet exc_en=1, code 0, val 0x8000_0002, HALT_EXC entered.
REQ-029 redirect_en asserted while FIFO full and out_ready=1 -> next cycle out_valid=0, pc_addr=redirect_pc; following cycle out_pc=redirect_pc.
REQ-030 rst_n pulsed low mid-stream in HALT_EXC -> out_valid=0 and fetch_stalled=0 immediately (asynchronously), pc_addr=0x8000_0000.
